// File: rtl/mult_8x8_e_1111.sv
// Registered 8x8 unsigned approximate multiplier.
// Four 4x4 "e" blocks built from 2x2 cells where 3x3 yields 7.
module mult_8x8_e_1111 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic        in_valid,
    output logic [15:0] R,
    output logic        out_valid
);

    // 2x2 cell: exact except 3x3, which collapses to 3'b111.
    function automatic logic [2:0] cell2(
        input logic [1:0] a,
        input logic [1:0] b
    );
        logic all1;
        all1 = &{a, b};
        cell2[0] = a[0] & b[0];
        cell2[1] = (a[1] & b[0]) ^ (a[0] & b[1]) | all1;
        cell2[2] = a[1] & b[1];
    endfunction

    function automatic logic [7:0] blk4(
        input logic [3:0] a,
        input logic [3:0] b
    );
        logic [2:0] ll;
        logic [2:0] hl;
        logic [2:0] lh;
        logic [2:0] hh;
        ll = cell2(a[1:0], b[1:0]);
        hl = cell2(a[3:2], b[1:0]);
        lh = cell2(a[1:0], b[3:2]);
        hh = cell2(a[3:2], b[3:2]);
        blk4 = {5'd0, ll}
             + {3'd0, hl, 2'd0}
             + {3'd0, lh, 2'd0}
             + {1'b0, hh, 4'd0};
    endfunction

    logic [7:0]  pLL;
    logic [7:0]  pHL;
    logic [7:0]  pLH;
    logic [7:0]  pHH;
    logic [15:0] rNext;

    always_comb begin
        pLL   = blk4(A[3:0], B[3:0]);
        pHL   = blk4(A[7:4], B[3:0]);
        pLH   = blk4(A[3:0], B[7:4]);
        pHH   = blk4(A[7:4], B[7:4]);
        rNext = {8'd0, pLL}
              + {4'd0, pHL, 4'd0}
              + {4'd0, pLH, 4'd0}
              + {pHH, 8'd0};
    end

    // R loads every cycle; valid only qualifies it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            R         <= 16'h0000;
            out_valid <= 1'b0;
        end else begin
            R         <= rNext;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_mult_8x8_e_1111.sv
// Scoreboard bench for mult_8x8_e_1111.
// Reference: exact product minus 2*4^(i+j) per 3x3 digit pair.
module tb_mult_8x8_e_1111;

    logic        clk;
    logic        rst_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        in_valid;
    logic [15:0] R;
    logic        out_valid;

    typedef struct {
        logic        v;
        logic [15:0] r;
        logic [7:0]  a;
        logic [7:0]  b;
        bit          chk;
    } exp_t;

    exp_t q[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   maxErr  = 0;
    bit   driveDone = 0;

    mult_8x8_e_1111 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .R         (R),
        .out_valid (out_valid)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic int model(input int a, input int b);
        int e;
        e = a * b;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (((a >> (2 * i)) & 3) == 3 && ((b >> (2 * j)) & 3) == 3)
                    e -= 2 << (2 * (i + j));
        return e;
    endfunction

    task automatic drive(input int a, input int b, input bit v, input bit rst);
        exp_t e;
        @(negedge clk);
        A = a[7:0];
        B = b[7:0];
        in_valid = v;
        rst_n = ~rst;
        e.a = a[7:0];
        e.b = b[7:0];
        if (rst) begin
            e.v = 0;
            e.r = 16'h0000;
            e.chk = 0;
        end else begin
            e.v = v;
            e.r = 16'(model(a, b));
            e.chk = 1;
        end
        q.push_back(e);
    endtask

    // Monitor: one expectation retires per clock edge.
    initial begin
        exp_t e;
        int exact;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                nChecks++;
                if (out_valid !== e.v || R !== e.r) begin
                    nFails++;
                    $display("FAIL result A=%0d B=%0d: got R=%0d v=%b, want R=%0d v=%b",
                             e.a, e.b, R, out_valid, e.r, e.v);
                end
                if (e.chk) begin
                    exact = int'(e.a) * int'(e.b);
                    nChecks++;
                    if (int'(R) > exact) begin
                        nFails++;
                        $display("FAIL underest A=%0d B=%0d: got R=%0d, want <= %0d",
                                 e.a, e.b, R, exact);
                    end
                    if (exact - int'(R) > maxErr) maxErr = exact - int'(R);
                end
            end
        end
    end

    initial begin
        int pts[6][3] = '{'{3, 3, 7}, '{2, 3, 6}, '{48, 3, 112},
                          '{255, 3, 595}, '{255, 1, 255}, '{200, 100, 20000}};
        int budget;
        A = 0;
        B = 0;
        in_valid = 0;
        rst_n = 0;
        // Reset overrides valid inputs
        drive(255, 255, 1, 1);
        drive(255, 255, 1, 1);
        drive(255, 255, 1, 0);
        // Point checks, back to back; model must agree with listed values
        foreach (pts[k]) begin
            nChecks++;
            if (model(pts[k][0], pts[k][1]) != pts[k][2]) begin
                nFails++;
                $display("FAIL refpoint A=%0d B=%0d: got %0d, want %0d",
                         pts[k][0], pts[k][1], model(pts[k][0], pts[k][1]), pts[k][2]);
            end
            drive(pts[k][0], pts[k][1], 1, 0);
        end
        for (int i = 0; i < 16; i++) drive(i, i, 1, 0);
        for (int b = 0; b < 256; b++) drive(0, b, 1, 0);
        for (int b = 0; b < 256; b++) drive(1, b, 1, 0);
        for (int a = 0; a < 256; a += 17) drive(a, 255, 1, 0);
        // Mid-stream reset discards in-flight product
        drive(255, 255, 1, 0);
        drive(200, 200, 1, 1);
        drive(77, 99, 1, 0);
        // Valid toggling; R still updates while invalid
        for (int i = 0; i < 64; i++)
            drive($urandom_range(255), $urandom_range(255), i[0], 0);
        for (int i = 0; i < 6000; i++)
            drive($urandom_range(255), $urandom_range(255),
                  $urandom_range(3) != 0, 0);
        drive(255, 255, 1, 0);
        budget = 100;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        nChecks++;
        if (q.size() != 0) begin
            nFails++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        nChecks++;
        if (maxErr != 14450) begin
            nFails++;
            $display("FAIL maxerr: got %0d, want 14450", maxErr);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/mult_8x8_e_1111.md
# mult_8x8_e_1111

Registered 8x8 unsigned approximate multiplier for FPGA datapaths that tolerate bounded under-estimation in exchange for fewer LUTs. The product is built from four 4x4 sub-multipliers, all four of the approximate "e" type (hence the suffix 1111). Each 4x4 block is in turn built from 2x2 approximate cells. The block sits in the arithmetic datapath and is characterised offline by exhaustive sweep: error count, total error distance, mean relative error distance and maximum error.

## Interface
- No parameters; all widths are fixed.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- A  input  8  unsigned multiplicand.
- B  input  8  unsigned multiplier.
- in_valid  input  1  qualifies A/B for the current cycle.
- R  output  16  unsigned approximate product, registered.
- out_valid  output  1  high when R holds a product of a valid input pair.

## Operation
- 2x2 cell, inputs a[1:0] and b[1:0]:
  - output is the exact product, except 3x3 yields 7 (binary 111) instead of 9;
  - output width is 3 bits.
- 4x4 approx block, inputs a[3:0] and b[3:0]:
  - split into ah=a[3:2], al=a[1:0], bh=b[3:2], bl=b[1:0];
  - P4 = cell(al,bl) + (cell(ah,bl)<<2) + (cell(al,bh)<<2) + (cell(ah,bh)<<4);
  - addition is exact, 8-bit result.
- 8x8 block:
  - split into AH=A[7:4], AL=A[3:0], BH=B[7:4], BL=B[3:0];
  - R_next = P4(AL,BL) + (P4(AH,BL)<<4) + (P4(AL,BH)<<4) + (P4(AH,BH)<<8);
  - addition is exact, 16-bit, with no truncation of low bits.
- Error properties the verifier relies on:
  - R ≤ A*B always, so the error is one-sided and never overestimates;
  - R == A*B iff no 2x2 sub-pair is 3x3;
  - any operand 0 gives R=0;
  - maximum result 50575, at A=B=255 (exact 65025).
- The core is purely combinational between the input pins and the R register; no internal pipeline stages.
- Implementation freedom: any LUT/carry-chain mapping, provided the result is bit-exact with the equations above for all 65536 input pairs.

## Timing
- Latency 1 cycle: A/B/in_valid sampled at edge n produce R and out_valid after edge n.
- Throughput 1 product per cycle; no backpressure and no handshake beyond valid.
- Register update rules:
  - R is loaded every cycle regardless of in_valid;
  - out_valid <= in_valid.
- Reset: when rst_n=0 at a rising edge, R <= 16'h0000 and out_valid <= 0.
  - This overrides a simultaneous in_valid.
  - Reset asserted mid-stream discards the in-flight product.
  - The first valid result appears 1 cycle after the first in_valid edge following rst_n release.
- No asynchronous paths to outputs; the outputs are stable for the full cycle.

## Test plan
- Reset: hold rst_n=0 with A=255, B=255, in_valid=1 for 2 edges -> R=0, out_valid=0. Release reset -> next edge R=50575, out_valid=1.
- Point checks, one per cycle, back-to-back:
  - A=3, B=3 -> R=7;
  - A=2, B=3 -> R=6;
  - A=48, B=3 -> R=112;
  - A=255, B=3 -> R=595;
  - A=255, B=1 -> R=255;
  - A=200, B=100 -> R=20000.
- Latency and throughput: stream A=i, B=i for i=0..15 with in_valid=1 -> each R appears exactly one cycle later with no bubbles.
- Zero and identity: A=0, B=any -> R=0. A=1, B=b for all b -> R=b wherever b contains no 2-bit field of 3 in the same position as a 3 in A.
- Exhaustive sweep over all 65536 (A,B) pairs, compared against a golden model built from the equations above:
  - bit-exact match required;
  - R ≤ A*B for every pair;
  - maximum absolute error = 14450, at A=B=255.
- in_valid toggling: alternate in_valid 1/0 -> out_valid mirrors the pattern one cycle later; R still updates when in_valid=0.
